// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: D/E/M pipeline status in, per-stage stall/bubble
// controls and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       D_reg_raddr1_i;
  logic [4:0]       D_reg_raddr2_i;
  logic             D_rs1_used_i;
  logic             D_rs2_used_i;
  logic [4:0]       E_reg_waddr_i;
  logic             E_reg_wen_i;
  logic             E_reg_mux_i;
  logic             E_multi_i;
  logic             E_branch_taken_i;
  logic             M_mem_req_i;
  logic             M_mem_ack_i;

  logic             F_stall_o;
  logic             D_stall_o;
  logic             D_bubble_o;
  logic             E_stall_o;
  logic             E_bubble_o;
  logic             M_stall_o;
  logic             M_bubble_o;
  logic             W_bubble_o;
  logic             ex_busy_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output D_reg_raddr1_i, D_reg_raddr2_i, D_rs1_used_i, D_rs2_used_i,
           E_reg_waddr_i, E_reg_wen_i, E_reg_mux_i, E_multi_i, E_branch_taken_i,
           M_mem_req_i, M_mem_ack_i,
    input  F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
           M_stall_o, M_bubble_o, W_bubble_o, ex_busy_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  D_reg_raddr1_i, D_reg_raddr2_i, D_rs1_used_i, D_rs2_used_i,
           E_reg_waddr_i, E_reg_wen_i, E_reg_mux_i, E_multi_i, E_branch_taken_i,
           M_mem_req_i, M_mem_ack_i,
    output F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
           M_stall_o, M_bubble_o, W_bubble_o, ex_busy_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: prioritised stall/bubble
// generation, multi-cycle execute sequencer and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_hazard_ctrl_if.slave   hz_if
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] LAST_CNT = 4'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait, ex_stall, redirect, load_use;
  logic f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_bubble;

  logic [4:0] src_addr [2];
  logic       src_used [2];
  logic [1:0] src_hit;

  assign src_addr[0] = hz_if.D_reg_raddr1_i;
  assign src_addr[1] = hz_if.D_reg_raddr2_i;
  assign src_used[0] = hz_if.D_rs1_used_i;
  assign src_used[1] = hz_if.D_rs2_used_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] & (src_addr[gi] == hz_if.E_reg_waddr_i);
    end
  endgenerate

  assign mem_wait = hz_if.M_mem_req_i & ~hz_if.M_mem_ack_i;
  assign redirect = hz_if.E_branch_taken_i & ~ex_stall & ~mem_wait;
  assign load_use = hz_if.E_reg_mux_i & hz_if.E_reg_wen_i &
                    (hz_if.E_reg_waddr_i != 5'd0) & (|src_hit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz_if.E_multi_i) begin
          ex_stall = 1'b1;
          state_d  = BUSY;
          cnt_d    = 4'd1;
        end
      end
      BUSY: begin
        if (cnt_q != LAST_CNT) begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // The whole pipe is frozen behind memory, so the op's occupancy count is too.
    if (mem_wait) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_stall  = 1'b0;
    e_bubble = 1'b0;
    m_stall  = 1'b0;
    m_bubble = 1'b0;
    w_bubble = 1'b0;
    if (!rst_i) begin
      if (mem_wait) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_stall  = 1'b1;
        m_stall  = 1'b1;
        w_bubble = 1'b1;
      end else if (ex_stall) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_stall  = 1'b1;
        m_bubble = 1'b1;
      end else if (redirect) begin
        d_bubble = 1'b1;
        e_bubble = 1'b1;
      end else if (load_use) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, f_stall};
      flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, redirect};
    end
  end

  assign hz_if.F_stall_o   = f_stall;
  assign hz_if.D_stall_o   = d_stall;
  assign hz_if.D_bubble_o  = d_bubble;
  assign hz_if.E_stall_o   = e_stall;
  assign hz_if.E_bubble_o  = e_bubble;
  assign hz_if.M_stall_o   = m_stall;
  assign hz_if.M_bubble_o  = m_bubble;
  assign hz_if.W_bubble_o  = w_bubble;
  assign hz_if.ex_busy_o   = (state_q == BUSY);
  assign hz_if.stall_cnt_o = stall_cnt_q;
  assign hz_if.flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage RV64 pipeline. It produces the stall/bubble pairs consumed by the F, D, E, M and W pipeline registers. It resolves four event classes:
- data-memory wait in M
- multi-cycle execute ops (MUL/DIV) in E
- taken-branch/jump redirect from E
- load-use hazards between D and E

It also keeps two free-running performance counters.

## Interface

Parameters:
- MUL_LAT, default 4: total cycles a multi-cycle op occupies E; legal range 2..16.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- D_reg_raddr1_i  in  5  rs1 index of the instruction in D.
- D_reg_raddr2_i  in  5  rs2 index of the instruction in D.
- D_rs1_used_i  in  1  instruction in D reads rs1.
- D_rs2_used_i  in  1  instruction in D reads rs2.
- E_reg_waddr_i  in  5  rd of the instruction in E.
- E_reg_wen_i  in  1  instruction in E writes rd.
- E_reg_mux_i  in  1  1 = instruction in E is a load (rd comes from memory).
- E_multi_i  in  1  instruction in E is a multi-cycle op.
- E_branch_taken_i  in  1  instruction in E redirects the PC.
- M_mem_req_i  in  1  instruction in M accesses data memory.
- M_mem_ack_i  in  1  data memory completes the access this cycle.
- F_stall_o  out  1  hold PC.
- D_stall_o, D_bubble_o  out  1 each  D register control.
- E_stall_o, E_bubble_o  out  1 each  E register control.
- M_stall_o, M_bubble_o  out  1 each  M register control.
- W_bubble_o  out  1  W register control.
- ex_busy_o  out  1  multi-cycle FSM is in BUSY.
- stall_cnt_o  out  CNT_W  cycles with F_stall_o = 1.
- flush_cnt_o  out  CNT_W  redirects taken.

## Operation

Internal conditions:
- mem_wait = M_mem_req_i & ~M_mem_ack_i.
- ex_stall = FSM stall term (see FSM below).
- redirect = E_branch_taken_i & ~ex_stall & ~mem_wait.
- load_use = E_reg_mux_i & E_reg_wen_i & (E_reg_waddr_i != 0) & ((D_rs1_used_i & raddr1 == waddr) | (D_rs2_used_i & raddr2 == waddr)).

Output priority, highest first; exactly one row applies and unlisted outputs are 0:
1. mem_wait: F/D/E/M stall = 1; W_bubble_o = 1.
2. ex_stall: F/D/E stall = 1; M_bubble_o = 1.
3. redirect: D_bubble_o = 1, E_bubble_o = 1. F is not stalled, so it loads the target.
4. load_use: F/D stall = 1; E_bubble_o = 1.
5. Otherwise all outputs are 0.

Redirect beats load_use, because the D instruction is wrong-path. A stall never coincides with a bubble on the same register.

Multi-cycle FSM, states IDLE and BUSY, with counter cnt (4 bits):
- IDLE & E_multi_i: ex_stall = 1; next state BUSY, cnt <= 1.
- BUSY & cnt != MUL_LAT-1: ex_stall = 1; cnt <= cnt+1.
- BUSY & cnt == MUL_LAT-1: ex_stall = 0 (op leaves E this edge); next state IDLE, cnt <= 0.
- While mem_wait = 1, state and cnt are frozen. ex_stall is still computed but is masked by priority.

Performance counters:
- stall_cnt_o increments on every edge with F_stall_o = 1; wraps modulo 2^CNT_W.
- flush_cnt_o increments on every edge with redirect = 1; wraps.

## Timing

- Stall/bubble outputs are combinational from inputs and FSM state, with zero-cycle latency. Registers act on the same edge.
- A multi-cycle op entering E at edge N holds E for exactly MUL_LAT cycles, with stall asserted for MUL_LAT-1 of them, and advances at edge N+MUL_LAT. Memory-wait cycles add to this 1:1.
- Back-to-back multi-cycle ops: the FSM returns to IDLE at the release edge and re-enters BUSY on the next cycle with no gap.
- Load-use costs exactly one bubble: on the next cycle the load is in M and E_reg_mux_i refers to the bubble.
- While rst_i = 1, all outputs are 0, the FSM is IDLE, cnt = 0 and the counters are 0. Reset asserted mid-BUSY aborts the count immediately.
- Reset release is synchronous to the next clk_i edge.

## Test plan

- Load-use: E = load, rd = x5, wen = 1; D raddr1 = 5, rs1_used = 1 -> F/D stall = 1, E_bubble_o = 1 for one cycle, stall_cnt_o = 1. Repeat with rd = x0 -> no stall.
- Redirect over load-use: load_use and E_branch_taken_i both true -> D_bubble_o = E_bubble_o = 1, no stall, flush_cnt_o +1.
- MUL_LAT = 4: E_multi_i held high -> F/D/E stall high for 3 cycles and M_bubble_o high for 3 cycles. ex_busy_o is high on cycles 2-4; cycle 4 has no stall. Back-to-back second op -> another 3 stall cycles.
- Memory wait during BUSY: M_mem_req_i = 1, ack = 0 for 2 cycles at cnt = 2 -> F/D/E/M stall, W_bubble_o = 1, cnt is frozen, and total E occupancy is 6 cycles.
- Reset mid-BUSY: assert rst_i at cnt = 2 -> outputs go to 0 immediately and counters are 0. After release with E_multi_i = 1, a full 3-cycle stall restarts.
- Counter wrap (CNT_W = 4): 17 stall cycles -> stall_cnt_o = 1.
